// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: byte-lane steering for stores, lane select and
// sign/zero extension for loads, fault detection, and a fixed-latency response.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [2:0]        lat_cnt;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rd_word;

    logic              accept;
    logic [AW-1:0]     idx;
    logic [ADDR_W-1:0] hi_bits;
    logic              out_of_range;
    logic              misaligned;
    logic              bad_funct3;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_fmt;

    assign accept       = req_valid && req_ready;
    assign idx          = req_addr[AW+1:2];
    assign hi_bits      = req_addr >> (AW + 2);
    assign out_of_range = (hi_bits != '0);
    assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign bad_funct3   = req_we ? !(req_funct3 inside {3'b000, 3'b001, 3'b010})
                                 :  (req_funct3 inside {3'b011, 3'b110, 3'b111});
    assign req_err      = out_of_range || misaligned || bad_funct3;

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Memory is not reset; the raw word is captured at acceptance and formatted later.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_we && !req_err) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                    end
                end
            end
            if (!req_we) begin
                rd_word <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            lat_cnt   <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            lane_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        lane_q    <= req_addr[1:0];
                        err_q     <= req_err;
                        lat_cnt   <= 3'(READ_LAT - 1);
                        req_ready <= 1'b0;
                        if (READ_LAT <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ld_byte = rd_word[8*lane_q +: 8];
    assign ld_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_fmt = '0;
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_fmt = rd_word;
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = '0;
        endcase
    end

    // Gating by rsp_valid keeps outputs at zero outside a response, including in reset.
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ld_fmt : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DEPTH_WORDS=4096, READ_LAT=3).
module tb_dmem_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int fails  = 0;

    dmem_ctrl #(.DEPTH_WORDS(4096), .ADDR_W(32), .READ_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Drives one request, measures acceptance-to-valid latency, consumes the response.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; e = rsp_err;
        if (n >= 20) lat = 99;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
        // Request presented in the release cycle must not be taken.
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
        repeat (LAT + 1) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL release_no_rsp: got %b expected 0", rsp_valid); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, e, lat);
        checks++; if (lat !== LAT) begin fails++; $display("FAIL sw_lat: got %0d expected %0d", lat, LAT); end
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sw_rsp: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
        access(1'b0, 3'b010, 32'h100, 32'h0, rd, e, lat);
        checks++; if (lat !== LAT) begin fails++; $display("FAIL lw_lat: got %0d expected %0d", lat, LAT); end
        checks++; if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got err=%b rdata=%h expected err=0 rdata=deadbeef", e, rd); end
        // Last in-range word.
        access(1'b1, 3'b010, 32'h3FFC, 32'h5A5AC3C3, rd, e, lat);
        access(1'b0, 3'b010, 32'h3FFC, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'h5A5AC3C3) begin fails++; $display("FAIL lw_top: got err=%b rdata=%h expected err=0 rdata=5a5ac3c3", e, rd); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] adrs [5] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000034};
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 3'b010, 32'h200, 32'h80FF1234, rd, e, lat);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, f3s[i], adrs[i], 32'h0, rd, e, lat);
            checks++;
            if (e !== 1'b0 || rd !== exps[i] || lat !== LAT) begin
                fails++;
                $display("FAIL load_ext[%0d]: got err=%b rdata=%h lat=%0d expected err=0 rdata=%h lat=%0d",
                         i, e, rd, lat, exps[i], LAT);
            end
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 3'b010, 32'h300, 32'h11223344, rd, e, lat);
        access(1'b1, 3'b000, 32'h301, 32'hCAFEBEAA, rd, e, lat);
        access(1'b0, 3'b010, 32'h300, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h1122AA44) begin fails++; $display("FAIL sb_lane: got %h expected 1122aa44", rd); end
        access(1'b1, 3'b001, 32'h302, 32'h0000BEEF, rd, e, lat);
        access(1'b0, 3'b010, 32'h300, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hBEEFAA44) begin fails++; $display("FAIL sh_lane: got %h expected beefaa44", rd); end
    endtask

    task automatic test_faults();
        logic        wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] adrs [6] = '{32'h102, 32'h301, 32'h4000, 32'h100, 32'h300, 32'h201};
        logic [31:0] rd; logic e; int lat;
        for (int i = 0; i < 6; i++) begin
            access(wes[i], f3s[i], adrs[i], 32'h9876FEDC, rd, e, lat);
            checks++;
            if (e !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin
                fails++;
                $display("FAIL fault[%0d]: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d",
                         i, e, rd, lat, LAT);
            end
        end
        access(1'b0, 3'b010, 32'h300, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'hBEEFAA44) begin fails++; $display("FAIL fault_no_write: got err=%b rdata=%h expected err=0 rdata=beefaa44", e, rd); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'h300; req_funct3 = 3'b000;
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (n !== LAT) begin fails++; $display("FAIL bp_lat: got %0d expected %0d", n, LAT); end
        repeat (5) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80FF1234 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: got valid=%b rdata=%h err=%b req_ready=%b expected 1 80ff1234 0 0",
                         rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic e; int lat; int n;
        // Store accepted, then reset while it is still in the latency wait.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL wait_reset: got valid=%b req_ready=%b expected 0 0", rsp_valid, req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL wait_reset_ready: got %b expected 1", req_ready); end
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wait_reset_no_rsp: got %b expected 0", rsp_valid); end
        end
        // Response pending in RESP is dropped asynchronously.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL resp_reset: got valid=%b rdata=%h expected 0 0", rsp_valid, rsp_rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 3'b010, 32'h400, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'h0BADF00D || lat !== LAT) begin fails++; $display("FAIL store_survives_reset: got err=%b rdata=%h lat=%0d expected 0 0badf00d %0d", e, rd, lat, LAT); end
        access(1'b0, 3'b010, 32'h100, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL mem_survives_reset: got err=%b rdata=%h expected 0 deadbeef", e, rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_load_ext();
        test_store_lanes();
        test_faults();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised RV32I data-memory controller that sits between the core's load/store unit and a word-organised, byte-writable data RAM. It takes one access request at a time over a valid/ready handshake. It performs RV32I byte-lane steering for SB/SH/SW and sign or zero extension for LB/LH/LW/LBU/LHU. It detects misaligned, out-of-range and illegal-funct3 accesses, and returns each result over a back-pressurable response channel after a configurable read latency.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; must be a power of two, ≥ 2.
- ADDR_W, 32: width of the byte address.
- READ_LAT, 1: cycles from request acceptance to rsp_valid; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  formatted load data; 0 for stores and for errored accesses.
- rsp_err  out  1  access faulted; no memory write was performed.

## Operation
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]; the byte lane is req_addr[1:0].
- Error conditions:
  - Out of range: any req_addr bit above log2(DEPTH_WORDS)+1 is set.
  - Misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
  - Illegal funct3: a load with 011/110/111, or a store with any code other than 000/001/010.
  - Any of these sets rsp_err=1 and rsp_rdata=0, and blocks the write.
- Stores:
  - Byte enables: SB sets the single lane selected by addr[1:0]; SH sets lanes {addr[1]*2, addr[1]*2+1}; SW sets all four lanes.
  - Data is replicated into lanes: byte to all four lanes, halfword to both halves.
  - Only enabled lanes are written. The write commits on the acceptance edge.
- Loads:
  - The full word is read on the acceptance edge, then the lane is selected.
  - LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend.
- FSM:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we, funct3, addr[1:0] and error flags, load lat_cnt=READ_LAT-1, and go to WAIT (or to RESP if READ_LAT=1).
  - WAIT: decrement lat_cnt; go to RESP when lat_cnt=1.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- One outstanding access. req_ready=0 in WAIT and RESP.
- rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- A load after a store to the same word always returns the new data, because the write completes before the next acceptance.
- Memory contents are not reset.

## Timing
- Reset values (while rst_n=0 and immediately after): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, lat_cnt=0. req_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Request accepted at edge T → rsp_valid first high in cycle T+READ_LAT.
- Response handshake at edge R → state IDLE and req_ready=1 in cycle R+1. Peak throughput is one access per READ_LAT+1 cycles.
- rsp_ready may be high before rsp_valid. A response is consumed only at an edge where both are high.
- Reset mid-operation:
  - Any pending response is discarded; rsp_valid drops asynchronously.
  - A store accepted before reset remains written.
  - A request presented in the reset-release cycle is not accepted.
- req_* inputs are sampled only on the acceptance edge; changes at any other time are ignored.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 → rsp_rdata=0xDEADBEEF, rsp_err=0, with rsp_valid exactly READ_LAT cycles after each acceptance.
- SW 0x80FF1234 @0x200, then:
  - LB @0x203 → 0xFFFFFF80
  - LBU @0x203 → 0x00000080
  - LH @0x202 → 0xFFFF80FF
  - LHU @0x202 → 0x000080FF
  - LB @0x200 → 0x00000034
- SW 0x11223344 @0x300, then SB wdata=0xCAFEBEAA @0x301 → LW @0x300 returns 0x1122AA44. SH wdata=0x0000BEEF @0x302 → LW @0x300 returns 0xBEEFAA44.
- Fault checks with DEPTH_WORDS=4096:
  - LW @0x102 → rsp_err=1, rdata=0.
  - SH @0x301 → rsp_err=1, and word 0x300 is unchanged.
  - LW @0x4000 → rsp_err=1.
  - Load with funct3=011 → rsp_err=1.
- Back-pressure with READ_LAT=3: hold rsp_ready=0 for 5 cycles after rsp_valid rises. rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. Raising rsp_ready gives req_ready=1 in the next cycle.
- Pull rst_n low while in WAIT after an accepted LW → rsp_valid=0 immediately and no response ever issues. req_ready=1 in the first cycle after release, and a following LW returns the pre-reset memory contents.
